// File: rtl/evt_pkt_arbiter_if.sv
// Handshake bundle for evt_pkt_arbiter: N input event streams, one output stream, status.
// The slave modport is the arbiter's side; master is the surrounding fabric.
interface evt_pkt_arbiter_if #(
  parameter int N_INP  = 2,
  parameter int DATA_W = 32
);
  localparam int IDX_W = (N_INP > 1) ? $clog2(N_INP) : 1;

  logic [N_INP-1:0][DATA_W-1:0] inp_data_i;
  logic [N_INP-1:0]             inp_valid_i;
  logic [N_INP-1:0]             inp_last_i;
  logic [N_INP-1:0]             inp_ready_o;
  logic [DATA_W-1:0]            oup_data_o;
  logic                         oup_valid_o;
  logic                         oup_last_o;
  logic                         oup_ready_i;
  logic                         busy_o;
  logic [IDX_W-1:0]             grant_idx_o;
  logic                         err_timeout_o;

  modport slave (
    input  inp_data_i, inp_valid_i, inp_last_i, oup_ready_i,
    output inp_ready_o, oup_data_o, oup_valid_o, oup_last_o,
           busy_o, grant_idx_o, err_timeout_o
  );

  modport master (
    output inp_data_i, inp_valid_i, inp_last_i, oup_ready_i,
    input  inp_ready_o, oup_data_o, oup_valid_o, oup_last_o,
           busy_o, grant_idx_o, err_timeout_o
  );
endinterface

// File: rtl/evt_pkt_arbiter.sv
// Packet-locking N:1 event arbiter (round-robin or fixed priority), zero-latency datapath.
// Optional stall watchdog enabled by defining SNE_EVT_ARB_TIMEOUT_EN.

module evt_pkt_arbiter_lane #(
  parameter int DATA_W = 32
) (
  input  logic              sel_i,
  input  logic              valid_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              oup_ready_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic              last_o,
  output logic [DATA_W-1:0] data_o
);
  assign valid_o = sel_i & valid_i;
  assign ready_o = valid_o & oup_ready_i;
  assign last_o  = valid_o & last_i;
  assign data_o  = sel_i ? data_i : '0;
endmodule

module evt_pkt_arbiter #(
  parameter int    N_INP          = 2,
  parameter int    DATA_W         = 32,
  parameter string ARBITER        = "rr",
  parameter int    TIMEOUT_CYCLES = 256
) (
  input logic              clk_i,
  input logic              rst_i,
  evt_pkt_arbiter_if.slave bus
);
  localparam int IDX_W = (N_INP > 1) ? $clog2(N_INP) : 1;
  localparam bit PRIO  = (ARBITER == "prio");

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rr_ptr_q, lock_idx_q, grant_q;
  logic             busy_q;

  logic             any_vld;
  logic [IDX_W-1:0] arb_sel, cur_idx, grant_d, cand;
  logic             found;
  int               start, idx;
  logic             xfer, xfer_last, to_fire;

  logic [N_INP-1:0]             lane_vld, lane_last, lane_rdy;
  logic [N_INP-1:0][DATA_W-1:0] lane_data;
  logic [DATA_W-1:0]            oup_data;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(N_INP - 1)) ? '0 : v + 1'b1;
  endfunction

  // Search upward from the rr pointer (or from 0 for priority), wrapping at N_INP.
  always_comb begin
    any_vld = |bus.inp_valid_i;
    arb_sel = '0;
    found   = 1'b0;
    cand    = '0;
    idx     = 0;
    start   = PRIO ? 0 : int'(rr_ptr_q);
    for (int k = 0; k < N_INP; k++) begin
      idx = start + k;
      if (idx >= N_INP) idx = idx - N_INP;
      cand = IDX_W'(idx);
      if (!found && bus.inp_valid_i[cand]) begin
        found   = 1'b1;
        arb_sel = cand;
      end
    end
  end

  assign cur_idx = (state_q == LOCKED) ? lock_idx_q : arb_sel;
  assign grant_d = (state_q == LOCKED) ? lock_idx_q : (any_vld ? arb_sel : grant_q);

  for (genvar i = 0; i < N_INP; i++) begin : g_lane
    evt_pkt_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
      .sel_i       (cur_idx == IDX_W'(i)),
      .valid_i     (bus.inp_valid_i[i]),
      .last_i      (bus.inp_last_i[i]),
      .data_i      (bus.inp_data_i[i]),
      .oup_ready_i (bus.oup_ready_i),
      .ready_o     (lane_rdy[i]),
      .valid_o     (lane_vld[i]),
      .last_o      (lane_last[i]),
      .data_o      (lane_data[i])
    );
  end

  always_comb begin
    oup_data = '0;
    for (int i = 0; i < N_INP; i++) oup_data = oup_data | lane_data[i];
  end

  assign bus.inp_ready_o = lane_rdy;
  assign bus.oup_valid_o = |lane_vld;
  assign bus.oup_last_o  = |lane_last;
  assign bus.oup_data_o  = oup_data;
  assign bus.busy_o      = busy_q;
  assign bus.grant_idx_o = grant_d;

  assign xfer      = bus.oup_valid_o & bus.oup_ready_i;
  assign xfer_last = xfer & bus.oup_last_o;

`ifdef SNE_EVT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign stall_cnt_d       = stall_cnt_q + 1'b1;
  // Fires in the stall cycle that brings the count to the limit.
  assign to_fire           = (state_q == LOCKED) && !xfer &&
                             (stall_cnt_d == CNT_W'(TIMEOUT_CYCLES));
  assign bus.err_timeout_o = to_fire;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                    stall_cnt_q <= '0;
    else if (state_q == IDLE || xfer || to_fire)  stall_cnt_q <= '0;
    else                                          stall_cnt_q <= stall_cnt_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign to_fire           = 1'b0;
  assign bus.err_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      grant_q <= grant_d;
      case (state_q)
        IDLE: begin
          if (any_vld) begin
            if (xfer_last) begin
              rr_ptr_q <= wrap_inc(arb_sel);
            end else begin
              // Freeze the grant: a stalled or open packet is never re-arbitrated.
              state_q    <= LOCKED;
              lock_idx_q <= arb_sel;
              busy_q     <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (xfer_last || to_fire) begin
            state_q  <= IDLE;
            rr_ptr_q <= wrap_inc(lock_idx_q);
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_evt_pkt_arbiter.sv
// Scoreboard bench for evt_pkt_arbiter: one rr instance (u_rr) and one prio instance (u_prio).
// Timeout scenario runs only when SNE_EVT_ARB_TIMEOUT_EN is defined.
module tb_evt_pkt_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  typedef struct packed {logic [W-1:0] data; logic last;} beat_t;
  typedef struct packed {logic [W-1:0] data; logic last; logic [1:0] idx;} exp_t;

  logic clk, rst;
  logic [N-1:0][W-1:0] dat [2];
  logic [N-1:0]        vld [2];
  logic [N-1:0]        lst [2];
  logic                ordy [2];
  logic [N-1:0]        rdy [2];
  logic [W-1:0]        odat [2];
  logic                ovld [2], olst [2], busy [2], err [2];
  logic [1:0]          gnt [2];

  beat_t src_q [2][N][$];
  exp_t  pend_q[2][N][$];
  exp_t  exp_q [2][$];
  logic [N-1:0] fire [2];

  int n_chk = 0, n_fail = 0, seq = 0;

  evt_pkt_arbiter_if #(.N_INP(N), .DATA_W(W)) ifc0 ();
  evt_pkt_arbiter_if #(.N_INP(N), .DATA_W(W)) ifc1 ();

  assign ifc0.inp_data_i = dat[0];  assign ifc1.inp_data_i = dat[1];
  assign ifc0.inp_valid_i = vld[0]; assign ifc1.inp_valid_i = vld[1];
  assign ifc0.inp_last_i = lst[0];  assign ifc1.inp_last_i = lst[1];
  assign ifc0.oup_ready_i = ordy[0]; assign ifc1.oup_ready_i = ordy[1];
  assign rdy[0] = ifc0.inp_ready_o;  assign rdy[1] = ifc1.inp_ready_o;
  assign odat[0] = ifc0.oup_data_o;  assign odat[1] = ifc1.oup_data_o;
  assign ovld[0] = ifc0.oup_valid_o; assign ovld[1] = ifc1.oup_valid_o;
  assign olst[0] = ifc0.oup_last_o;  assign olst[1] = ifc1.oup_last_o;
  assign busy[0] = ifc0.busy_o;      assign busy[1] = ifc1.busy_o;
  assign gnt[0] = ifc0.grant_idx_o;  assign gnt[1] = ifc1.grant_idx_o;
  assign err[0] = ifc0.err_timeout_o; assign err[1] = ifc1.err_timeout_o;

  evt_pkt_arbiter #(.N_INP(N), .DATA_W(W), .ARBITER("rr"), .TIMEOUT_CYCLES(8))
    u_rr (.clk_i(clk), .rst_i(rst), .bus(ifc0));
  evt_pkt_arbiter #(.N_INP(N), .DATA_W(W), .ARBITER("prio"), .TIMEOUT_CYCLES(8))
    u_prio (.clk_i(clk), .rst_i(rst), .bus(ifc1));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_src(input int d, input int i, input int n, input bit close);
    beat_t b; exp_t e;
    for (int k = 0; k < n; k++) begin
      seq++;
      b.data = {8'(d), 8'(i), 16'(seq)};
      b.last = close && (k == n - 1);
      e.data = b.data; e.last = b.last; e.idx = 2'(i);
      src_q[d][i].push_back(b);
      pend_q[d][i].push_back(e);
    end
  endtask

  task automatic exp_pkt(input int d, input int i, input int n);
    for (int k = 0; k < n; k++) exp_q[d].push_back(pend_q[d][i].pop_front());
  endtask

  task automatic wait_drain(input int d, input int budget);
    int k = 0;
    while (exp_q[d].size() != 0 && k < budget) begin cyc(1); k++; end
    chk("drain", 64'(exp_q[d].size()), 64'd0);
  endtask

  // Source driver: retire beats that handshook on the last edge, then present the next.
  initial begin
    for (int d = 0; d < 2; d++) begin vld[d] = '0; lst[d] = '0; dat[d] = '0; fire[d] = '0; end
    forever begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < N; i++)
          if (fire[d][i]) void'(src_q[d][i].pop_front());
      #1;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < N; i++)
          if (src_q[d][i].size() > 0) begin
            vld[d][i] = 1'b1; dat[d][i] = src_q[d][i][0].data; lst[d][i] = src_q[d][i][0].last;
          end else begin
            vld[d][i] = 1'b0; dat[d][i] = '0; lst[d][i] = 1'b0;
          end
    end
  end

  // Output monitor: every transferred beat must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        fire[d] = vld[d] & rdy[d];
        if (ovld[d] && ordy[d]) begin
          if (exp_q[d].size() == 0) chk("unexpected_beat", 64'(odat[d]), 64'd0);
          else begin
            e = exp_q[d].pop_front();
            chk("beat_data", 64'(odat[d]), 64'(e.data));
            chk("beat_last", 64'(olst[d]), 64'(e.last));
            chk("beat_grant", 64'(gnt[d]), 64'(e.idx));
          end
        end
      end
    end
  end

  initial begin
    logic [W-1:0] held;
    rst = 1'b1; ordy[0] = 1'b0; ordy[1] = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 64'(ovld[d]), 64'd0);
      chk("rst_ready", 64'(rdy[d]), 64'd0);
      chk("rst_busy", 64'(busy[d]), 64'd0);
      chk("rst_grant", 64'(gnt[d]), 64'd0);
      chk("rst_err", 64'(err[d]), 64'd0);
    end
    @(posedge clk); #3 rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("post_rst_busy", 64'(busy[d]), 64'd0);
      chk("post_rst_grant", 64'(gnt[d]), 64'd0);
    end
    cyc(1);

    // rr: two simultaneous 3-beat packets, never interleaved
    ordy[0] = 1'b1;
    push_src(0, 0, 3, 1); push_src(0, 2, 3, 1);
    exp_pkt(0, 0, 3); exp_pkt(0, 2, 3);
    wait_drain(0, 20);

    // prio: lock held under backpressure against a higher-priority request
    ordy[1] = 1'b0;
    push_src(1, 1, 3, 1);
    held = pend_q[1][1][0].data;
    cyc(1);
    push_src(1, 0, 2, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_grant", 64'(gnt[1]), 64'd1);
      chk("bp_data", 64'(odat[1]), 64'(held));
      chk("bp_valid", 64'(ovld[1]), 64'd1);
      chk("bp_ready0", 64'(rdy[1][0]), 64'd0);
      cyc(1);
    end
    exp_pkt(1, 1, 3); exp_pkt(1, 0, 2);
    ordy[1] = 1'b1;
    wait_drain(1, 20);

    // source gap mid-packet while input 3 waits
    push_src(0, 1, 2, 0);
    exp_pkt(0, 1, 2);
    cyc(2);
    push_src(0, 3, 1, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("gap_valid", 64'(ovld[0]), 64'd0);
      chk("gap_ready3", 64'(rdy[0][3]), 64'd0);
      chk("gap_busy", 64'(busy[0]), 64'd1);
      cyc(1);
    end
    push_src(0, 1, 2, 1);
    exp_pkt(0, 1, 2); exp_pkt(0, 3, 1);
    wait_drain(0, 20);

    // single-beat packets on all inputs: rr rotates 0..3 each cycle, prio drains 0 first
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) begin push_src(0, i, 1, 1); push_src(1, i, 1, 1); end
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) exp_pkt(0, i, 1);
    for (int i = 0; i < N; i++) exp_pkt(1, i, 3);
    cyc(12);
    chk("rr_one_per_cycle", 64'(exp_q[0].size()), 64'd0);
    chk("prio_one_per_cycle", 64'(exp_q[1].size()), 64'd0);

`ifdef SNE_EVT_ARB_TIMEOUT_EN
    // watchdog: locked input stalls after its first beat
    push_src(0, 2, 1, 0);
    exp_pkt(0, 2, 1);
    cyc(1);
    push_src(0, 0, 1, 1);
    exp_pkt(0, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("tmo_pulse", 64'(err[0]), 64'(k == 8));
      chk("tmo_busy", 64'(busy[0]), 64'd1);
      cyc(1);
    end
    @(negedge clk);
    chk("tmo_released", 64'(busy[0]), 64'd0);
    chk("tmo_next_grant", 64'(gnt[0]), 64'd0);
    chk("tmo_err_clear", 64'(err[0]), 64'd0);
    wait_drain(0, 10);
`else
    chk("err_tied_rr", 64'(err[0]), 64'd0);
    chk("err_tied_prio", 64'(err[1]), 64'd0);
`endif

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/evt_pkt_arbiter.md
Name: evt_pkt_arbiter

Overview:
- Packet-aware N-to-1 arbiter for SNE event streams.
- Once an input wins arbitration, it keeps the output until its end-of-packet beat. Payloads of different packets are therefore never interleaved.
- Sits in the event crossbar in front of any shared sink that receives multi-beat packets: header plus payload events.
- Zero-latency pass-through datapath. Sequencing is done by a small lock FSM with round-robin or fixed-priority selection.

Parameters:
- N_INP, 2, number of requesting streams (≥2).
- DATA_W, 32, event word width in bits.
- ARBITER, "rr", "rr" = round-robin, "prio" = fixed priority (index 0 highest).
- TIMEOUT_CYCLES, 256, stall watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- inp_data_i  in  N_INP*DATA_W  event word per input.
- inp_valid_i  in  N_INP  input valid.
- inp_last_i  in  N_INP  marks the last beat of a packet.
- inp_ready_o  out  N_INP  input ready.
- oup_data_o  out  DATA_W  selected event word.
- oup_valid_o  out  1  output valid.
- oup_last_o  out  1  last beat of the forwarded packet.
- oup_ready_i  in  1  downstream ready.
- busy_o  out  1  1 while in LOCKED.
- grant_idx_o  out  $clog2(N_INP)  currently selected input index.
- err_timeout_o  out  1  one-cycle pulse when the watchdog fires (tied 0 when the feature is off).

Behaviour:
- Single clock; reset is asynchronous and active-high on rst_i.
- Handshake: a beat transfers when oup_valid_o & oup_ready_i. Valid/ready semantics are standard: once oup_valid_o is asserted, data, last and grant stay stable until the transfer.
- Reset values:
  - state = IDLE, rr_ptr = 0, lock_idx = 0.
  - busy_o = 0, grant_idx_o = 0, err_timeout_o = 0.
  - oup_valid_o and inp_ready_o follow the IDLE combinational rules. With no input valid, both are 0.
- Selection in IDLE:
  - "rr": the first valid index at or after rr_ptr, searching upward with wrap-around.
  - "prio": the lowest valid index.
- Datapath:
  - oup_data_o, oup_last_o and oup_valid_o are driven combinationally from the selected input (0-cycle latency).
  - Only the selected input sees inp_ready_o = oup_ready_i; all other inp_ready_o are 0.
- FSM, IDLE:
  - No input valid → stay in IDLE; oup_valid_o = 0; grant_idx_o holds its last value.
  - Selected beat transfers with last = 1 → stay in IDLE (single-beat packet); rr_ptr = sel+1 mod N_INP.
  - Any other case with an input valid (a stalled beat, or a transfer with last = 0) → LOCKED, lock_idx = sel. This freezes the grant so a stalled beat is never re-arbitrated.
- FSM, LOCKED:
  - Selection is forced to lock_idx regardless of other valids or priority.
  - A transfer with last = 1 → IDLE; rr_ptr = lock_idx+1 mod N_INP.
  - A gap (locked input valid = 0) keeps the lock; oup_valid_o = 0 and all inp_ready_o are 0.
- Wrap-around: the rr_ptr increment wraps N_INP-1 → 0 for any N_INP, including non-powers of two.
- Simultaneous requests:
  - rr: in IDLE, the winner is the first index ≥ rr_ptr.
  - Requests arriving while LOCKED are ignored until release. Arbitration on the release cycle happens in the next cycle (IDLE).
- Reset mid-packet: the lock is dropped immediately. The remainder of the packet is treated as a new request after reset. Framing is the sources' responsibility.
- An input asserting last on a beat that is not transferred has no effect.

Optional Feature:
- Macro: SNE_EVT_ARB_TIMEOUT_EN.
- When defined:
  - A counter (width $clog2(TIMEOUT_CYCLES+1)) increments each LOCKED cycle without a transfer. It clears on any transfer and on entering LOCKED.
  - On reaching TIMEOUT_CYCLES: force IDLE, pulse err_timeout_o for 1 cycle, and set rr_ptr = lock_idx+1.
  - The partial packet is abandoned and no beat is synthesised.
- When undefined: no counter logic; err_timeout_o is tied 0; LOCKED is held indefinitely.

Test Plan:
- Reset with N_INP=4, no valids → oup_valid_o=0, inp_ready_o=4'b0000, busy_o=0, grant_idx_o=0.
- rr: inputs 0 and 2 each send a 3-beat packet simultaneously, oup_ready_i=1 → output is 0,0,0 then 2,2,2 with oup_last_o only on beats 3 and 6; never interleaved.
- Lock under backpressure: input 1 valid with oup_ready_i=0 for 5 cycles while input 0 (higher prio, "prio") raises valid → grant stays 1 and data is stable; after ready rises, input 1 completes before input 0 is served.
- Source gap: the locked input drops valid for 3 cycles mid-packet while input 3 is valid → oup_valid_o=0 and inp_ready_o[3]=0 throughout; the packet resumes and completes.
- Single-beat packets on all 4 inputs continuously (rr) → grant sequence 0,1,2,3,0,… one per cycle; rr_ptr wraps 3→0.
- With SNE_EVT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: the locked input stalls after beat 1 → err_timeout_o pulses on the 8th stall cycle; busy_o=0 the next cycle; the next valid input is granted.
